// File: rtl/fpu_addsub_pipe.sv
// Floating-point add/subtract unit for the {sign, exponent, mantissa} format.
// One operation in flight: IDLE -> ALIGN -> OPERATE -> NORMALIZE -> ROUND -> DONE.
// Rounding is round-to-nearest-even on a {hidden, mant, G, R, S} working significand.
// status_out = {UNDERFLOW, OVERFLOW, INEXACT, EXACT}.
module fpu_addsub_pipe #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25
) (
  input  logic                   clock100KHz,
  input  logic                   reset,
  input  logic                   start_in,
  input  logic                   op_mode_in,
  input  logic [EXP_W+MAN_W:0]   op_A_in,
  input  logic [EXP_W+MAN_W:0]   op_B_in,
  output logic                   busy_out,
  output logic                   done_out,
  output logic [EXP_W+MAN_W:0]   data_out,
  output logic [3:0]             status_out
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 4;
  localparam int LZ_W = $clog2(SW);
  localparam int EW   = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);
  localparam logic signed [EW-1:0] EXP_LIMIT = EW'(2**EXP_W - 1);

  typedef enum logic [2:0] {
    IDLE, ALIGN, OPERATE, NORMALIZE, ROUND, DONE
  } state_t;

  state_t state, state_next;

  // Captured operands
  logic [W-1:0] a_q, b_q;
  logic         mode_q;

  // Alignment results
  logic [SW-1:0]    alg_big_q, alg_small_q;
  logic [EXP_W-1:0] alg_exp_q;
  logic             alg_sub_q, alg_sign_q;

  // Operate result (one extra bit for carry-out)
  logic [SW:0] sum_q;

  // Normalised value; the hidden bit is implicit here
  logic [SW-2:0]          nfrac_q;
  logic signed [EW-1:0]   nexp_q;
  logic                   nzero_q, nuf_q, nsign_q;

  // Combinational stage signals
  logic             sign_a, sign_b, a_big, al_sub, al_sign;
  logic [EXP_W-1:0] exp_a, exp_b, big_exp, small_exp, diff;
  logic [MAN_W:0]   sig_a, sig_b, big_sig, small_sig;
  logic [SW-1:0]    small_ext, shifted, lost_mask, al_big, al_small;
  logic [SW:0]      opr_sum;
  logic [LZ_W-1:0]  lzc;
  logic             found;
  logic [SW-2:0]    nrm_frac;
  logic signed [EW-1:0] nrm_exp, rnd_exp;
  logic             nrm_zero, nrm_uf, nrm_sign;
  logic             g_bit, r_bit, s_bit, inc, inexact;
  logic [MAN_W:0]   man_plus;
  logic [MAN_W-1:0] rnd_man;
  logic [W-1:0]     rnd_data;
  logic [3:0]       rnd_status;

  // State register
  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state sequencing and handshake outputs
  always_comb begin
    state_next = state;
    busy_out   = 1'b0;
    done_out   = 1'b0;
    case (state)
      IDLE:      if (start_in) state_next = ALIGN;
      ALIGN:     begin busy_out = 1'b1; state_next = OPERATE;   end
      OPERATE:   begin busy_out = 1'b1; state_next = NORMALIZE; end
      NORMALIZE: begin busy_out = 1'b1; state_next = ROUND;     end
      ROUND:     begin busy_out = 1'b1; state_next = DONE;      end
      DONE:      begin busy_out = 1'b1; done_out = 1'b1; state_next = IDLE; end
      default:   state_next = IDLE;
    endcase
  end

  // Operand decode: a zero exponent means zero, otherwise the hidden 1 is restored
  assign sign_a = a_q[W-1];
  assign sign_b = b_q[W-1] ^ mode_q;
  assign exp_a  = a_q[W-2:MAN_W];
  assign exp_b  = b_q[W-2:MAN_W];
  assign sig_a  = (exp_a == '0) ? '0 : {1'b1, a_q[MAN_W-1:0]};
  assign sig_b  = (exp_b == '0) ? '0 : {1'b1, b_q[MAN_W-1:0]};
  assign a_big  = {exp_a, sig_a} >= {exp_b, sig_b};

  // Align: shift the smaller operand right, folding lost bits into sticky
  always_comb begin
    big_exp   = a_big ? exp_a : exp_b;
    small_exp = a_big ? exp_b : exp_a;
    big_sig   = a_big ? sig_a : sig_b;
    small_sig = a_big ? sig_b : sig_a;
    diff      = big_exp - small_exp;
    small_ext = {small_sig, 3'b000};
    al_big    = {big_sig, 3'b000};
    shifted   = '0;
    lost_mask = '0;
    if (int'(diff) > MAN_W + 3) begin
      al_small = {{(SW-1){1'b0}}, |small_sig};
    end else begin
      shifted   = small_ext >> diff;
      lost_mask = (SW'(1) << diff) - SW'(1);
      al_small  = {shifted[SW-1:1], shifted[0] | (|(small_ext & lost_mask))};
    end
    al_sub  = sign_a ^ sign_b;
    al_sign = al_sub ? (a_big ? sign_a : sign_b) : sign_a;
  end

  // Operate: magnitude add or larger-minus-smaller
  always_comb begin
    if (alg_sub_q) opr_sum = {1'b0, alg_big_q} - {1'b0, alg_small_q};
    else           opr_sum = {1'b0, alg_big_q} + {1'b0, alg_small_q};
  end

  // Normalise: right shift on carry-out, else left shift by leading-zero count
  always_comb begin
    lzc      = '0;
    found    = 1'b0;
    nrm_frac = '0;
    nrm_exp  = '0;
    nrm_zero = 1'b0;
    nrm_uf   = 1'b0;
    nrm_sign = alg_sign_q;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found && sum_q[i]) begin
        lzc   = LZ_W'(SW - 1 - i);
        found = 1'b1;
      end
    end
    if (sum_q == '0) begin
      nrm_zero = 1'b1;
      nrm_sign = alg_sign_q & ~alg_sub_q;
    end else if (sum_q[SW]) begin
      nrm_frac = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
      nrm_exp  = EW'(alg_exp_q) + EW'(1);
    end else begin
      nrm_frac = (SW-1)'(sum_q[SW-1:0] << lzc);
      nrm_exp  = EW'(alg_exp_q) - EW'(lzc);
      if (nrm_exp < EXP_ONE) nrm_uf = 1'b1;
    end
  end

  // Round to nearest even, then resolve zero, underflow and overflow results
  always_comb begin
    g_bit    = nfrac_q[2];
    r_bit    = nfrac_q[1];
    s_bit    = nfrac_q[0];
    inc      = g_bit & (r_bit | s_bit | nfrac_q[3]);
    inexact  = g_bit | r_bit | s_bit;
    man_plus = {1'b0, nfrac_q[SW-2:3]} + (MAN_W+1)'(inc);
    if (man_plus[MAN_W]) begin
      rnd_man = '0;
      rnd_exp = nexp_q + EW'(1);
    end else begin
      rnd_man = man_plus[MAN_W-1:0];
      rnd_exp = nexp_q;
    end
    rnd_data   = '0;
    rnd_status = 4'b0001;
    if (nzero_q) begin
      rnd_data   = {nsign_q, {(W-1){1'b0}}};
      rnd_status = 4'b0001;
    end else if (nuf_q) begin
      rnd_data   = {nsign_q, {(W-1){1'b0}}};
      rnd_status = 4'b1010;
    end else if (rnd_exp >= EXP_LIMIT) begin
      rnd_data   = {nsign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_status = 4'b0110;
    end else begin
      rnd_data   = {nsign_q, rnd_exp[EXP_W-1:0], rnd_man};
      rnd_status = inexact ? 4'b0010 : 4'b0001;
    end
  end

  // Datapath registers, each loaded in the state that produces them
  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      alg_big_q   <= '0;
      alg_small_q <= '0;
      alg_exp_q   <= '0;
      alg_sub_q   <= 1'b0;
      alg_sign_q  <= 1'b0;
      sum_q       <= '0;
      nfrac_q     <= '0;
      nexp_q      <= '0;
      nzero_q     <= 1'b0;
      nuf_q       <= 1'b0;
      nsign_q     <= 1'b0;
      data_out    <= '0;
      status_out  <= '0;
    end else begin
      case (state)
        IDLE: if (start_in) begin
          a_q    <= op_A_in;
          b_q    <= op_B_in;
          mode_q <= op_mode_in;
        end
        ALIGN: begin
          alg_big_q   <= al_big;
          alg_small_q <= al_small;
          alg_exp_q   <= big_exp;
          alg_sub_q   <= al_sub;
          alg_sign_q  <= al_sign;
        end
        OPERATE: sum_q <= opr_sum;
        NORMALIZE: begin
          nfrac_q <= nrm_frac;
          nexp_q  <= nrm_exp;
          nzero_q <= nrm_zero;
          nuf_q   <= nrm_uf;
          nsign_q <= nrm_sign;
        end
        ROUND: begin
          data_out   <= rnd_data;
          status_out <= rnd_status;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed bench for fpu_addsub_pipe: a vector table plus handshake and reset sequences.
`timescale 1ns/1ps
module tb_fpu_addsub_pipe;

  logic        clock100KHz = 1'b0;
  logic        reset;
  logic        start_in;
  logic        op_mode_in;
  logic [31:0] op_A_in, op_B_in;
  logic        busy_out, done_out;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        mode;
    logic [31:0] exp_data;
    logic [3:0]  exp_status;
  } vec_t;

  vec_t vecs[$];

  fpu_addsub_pipe #(.EXP_W(6), .MAN_W(25)) dut (
    .clock100KHz (clock100KHz),
    .reset       (reset),
    .start_in    (start_in),
    .op_mode_in  (op_mode_in),
    .op_A_in     (op_A_in),
    .op_B_in     (op_B_in),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .data_out    (data_out),
    .status_out  (status_out)
  );

  // Free-running clock
  always #5 clock100KHz = ~clock100KHz;

  // Guard against a hung run
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called at a negedge while idle; start is sampled at the next rising edge (edge N)
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic mode);
    op_A_in    = a;
    op_B_in    = b;
    op_mode_in = mode;
    start_in   = 1'b1;
    @(posedge clock100KHz);
    #1 start_in = 1'b0;
  endtask

  // Returns how many rising edges after edge N done_out was first seen (0 = never)
  task automatic waitDone(output int latency);
    latency = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock100KHz);
      @(negedge clock100KHz);
      if (done_out) begin
        latency = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int done_cnt, busy_cnt, done_at;

    vecs.push_back('{"one_plus_one",      32'h3E000000, 32'h3E000000, 1'b0, 32'h40000000, 4'b0001});
    vecs.push_back('{"one_minus_one",     32'h3E000000, 32'h3E000000, 1'b1, 32'h00000000, 4'b0001});
    vecs.push_back('{"tie_even_lsb0",     32'h3E000000, 32'h0A000000, 1'b0, 32'h3E000000, 4'b0010});
    vecs.push_back('{"tie_even_lsb1",     32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000002, 4'b0010});
    vecs.push_back('{"overflow_max",      32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, 32'h7E000000, 4'b0110});
    vecs.push_back('{"underflow_flush",   32'h02000001, 32'h02000000, 1'b1, 32'h00000000, 4'b1010});
    vecs.push_back('{"x_plus_zero",       32'h3E000000, 32'h00000000, 1'b0, 32'h3E000000, 4'b0001});
    vecs.push_back('{"negz_plus_negz",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0001});
    vecs.push_back('{"negz_minus_posz",   32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0001});
    vecs.push_back('{"posz_plus_negz",    32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0001});
    vecs.push_back('{"one_minus_two",     32'h3E000000, 32'h40000000, 1'b1, 32'hBE000000, 4'b0001});
    vecs.push_back('{"far_sticky_only",   32'h3E000000, 32'h02000000, 1'b0, 32'h3E000000, 4'b0010});
    vecs.push_back('{"round_above_half",  32'h3E000000, 32'h0B000000, 1'b0, 32'h3E000001, 4'b0010});
    vecs.push_back('{"exp_tie_negative",  32'h3E000000, 32'h3F000000, 1'b1, 32'hBC000000, 4'b0001});
    vecs.push_back('{"carry_to_ovf",      32'h7C000000, 32'h7C000000, 1'b0, 32'h7E000000, 4'b0110});
    vecs.push_back('{"largest_finite",    32'h7A000000, 32'h7A000000, 1'b0, 32'h7C000000, 4'b0001});
    vecs.push_back('{"min_exp_result",    32'h04000000, 32'h02000000, 1'b1, 32'h02000000, 4'b0001});
    vecs.push_back('{"round_carry_out",   32'h3FFFFFFF, 32'h0B000000, 1'b0, 32'h40000000, 4'b0010});

    reset      = 1'b1;
    start_in   = 1'b0;
    op_mode_in = 1'b0;
    op_A_in    = '0;
    op_B_in    = '0;
    @(negedge clock100KHz);
    @(negedge clock100KHz);
    checkOutput("reset_data",   data_out,   32'h0);
    checkOutput("reset_status", {28'h0, status_out}, 32'h0);
    checkOutput("reset_busy",   {31'h0, busy_out},   32'h0);
    checkOutput("reset_done",   {31'h0, done_out},   32'h0);
    reset = 1'b0;
    @(negedge clock100KHz);

    // Each iteration starts in the idle cycle right after the previous DONE,
    // so back-to-back acceptance is exercised on every vector after the first.
    // Done in cycle N+5 means done_out is first high after the 4th edge past edge N.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].mode);
      waitDone(lat);
      checkOutput({vecs[i].name, "_latency"}, lat, 4);
      checkOutput({vecs[i].name, "_data"}, data_out, vecs[i].exp_data);
      checkOutput({vecs[i].name, "_status"}, {28'h0, status_out}, {28'h0, vecs[i].exp_status});
      @(posedge clock100KHz);
      @(negedge clock100KHz);
      checkOutput({vecs[i].name, "_done_pulse"}, {31'h0, done_out}, 32'h0);
    end

    // Second start while busy must be ignored: one done pulse, first result kept
    applyStimulus(32'h3E000000, 32'h3E000000, 1'b0);
    done_cnt = 0;
    busy_cnt = 0;
    done_at  = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock100KHz);
      if (busy_out) busy_cnt++;
      if (done_out) begin
        done_cnt++;
        done_at = k;
      end
      if (k == 0) begin
        op_A_in    = 32'h3E000000;
        op_B_in    = 32'h3E000000;
        op_mode_in = 1'b1;
        start_in   = 1'b1;
      end else if (k == 2) begin
        start_in = 1'b0;
      end
    end
    checkOutput("busy_ignore_done_count", done_cnt, 1);
    checkOutput("busy_ignore_done_cycle", done_at, 4);
    checkOutput("busy_ignore_busy_cycles", busy_cnt, 5);
    checkOutput("busy_ignore_data", data_out, 32'h40000000);

    // Reset in NORMALIZE clears outputs at once and suppresses done
    applyStimulus(32'h3E000000, 32'h3F000000, 1'b0);
    @(negedge clock100KHz);
    @(negedge clock100KHz);
    @(negedge clock100KHz);
    checkOutput("midop_busy_before_reset", {31'h0, busy_out}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("midop_reset_data",   data_out, 32'h0);
    checkOutput("midop_reset_status", {28'h0, status_out}, 32'h0);
    checkOutput("midop_reset_busy",   {31'h0, busy_out},   32'h0);
    checkOutput("midop_reset_done",   {31'h0, done_out},   32'h0);
    @(negedge clock100KHz);
    reset    = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock100KHz);
      @(negedge clock100KHz);
      if (done_out) done_cnt++;
    end
    checkOutput("midop_no_done", done_cnt, 0);

    applyStimulus(32'h3E000000, 32'h3F000000, 1'b0);
    waitDone(lat);
    checkOutput("after_reset_latency", lat, 4);
    checkOutput("after_reset_data", data_out, 32'h40800000);
    checkOutput("after_reset_status", {28'h0, status_out}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
